// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter/sequencer that shares one 32-bit ALU between two
//   clients. Accepts a request, drives the ALU for one cycle from registered
//   operands, captures result/zero and returns them on the owner's response
//   channel.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // client 0 request / response
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  output logic             resp0_err,
  // client 1 request / response
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic             resp1_err,
  // shared ALU
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  // Highest legal opcode (sll); anything above it is rejected.
  localparam logic [3:0] OP_MAX = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             rr;       // client favoured when both request at once
  logic             owner;    // client whose operation is in flight
  logic             err_q;    // in-flight opcode was illegal

  logic             grant0;
  logic             grant1;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_illegal;
  logic             owner_ready;

  // Grant selection: only in IDLE; round-robin pointer breaks ties.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr;
        grant1 = rr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Mux the granted client's request fields and classify the opcode.
  always_comb begin
    sel_op      = grant1 ? req1_op : req0_op;
    sel_a       = grant1 ? req1_a  : req0_a;
    sel_b       = grant1 ? req1_b  : req0_b;
    sel_illegal = (sel_op > OP_MAX);
    owner_ready = owner ? resp1_ready : resp0_ready;
  end

  assign busy = (state != IDLE);

  // Main sequencer: the ALU drive registers double as the latched operands,
  // so they are non-zero only while the FSM sits in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr           <= 1'b0;
      owner        <= 1'b0;
      err_q        <= 1'b0;
      alu_control  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp0_zero   <= 1'b0;
      resp0_err    <= 1'b0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      resp1_zero   <= 1'b0;
      resp1_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner <= grant1;
            err_q <= sel_illegal;
            if (sel_illegal) begin
              alu_control <= '0;
              alu_a       <= '0;
              alu_b       <= '0;
            end else begin
              alu_control <= sel_op;
              alu_a       <= sel_a;
              alu_b       <= sel_b;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          // Illegal ops report a forced zero result with a clear zero flag.
          if (owner) begin
            resp1_valid  <= 1'b1;
            resp1_result <= err_q ? '0 : alu_result;
            resp1_zero   <= err_q ? 1'b0 : alu_zero;
            resp1_err    <= err_q;
          end else begin
            resp0_valid  <= 1'b1;
            resp0_result <= err_q ? '0 : alu_result;
            resp0_zero   <= err_q ? 1'b0 : alu_zero;
            resp0_err    <= err_q;
          end
          alu_control <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
          state       <= RESP;
        end
        RESP: begin
          // Handing priority to the other client prevents starvation.
          if (owner_ready) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            rr          <= ~owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed, table-driven bench for alu_arbiter with a behavioural ALU.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 0, resp1_ready = 0;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero, resp0_err, resp1_err;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero), .resp1_err(resp1_err),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Behavioural ALU sitting on the arbiter's ALU port.
  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0110: alu_result = alu_a >> alu_b[4:0];
      4'b0111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b1000: alu_result = alu_a << alu_b[4:0];
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic        c;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left at a negedge: issue one request, check EXEC drive and
  // the response two cycles after acceptance, then consume it.
  task automatic run_vec(input vec_t v);
    if (v.c) begin
      req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end
    #1;
    chk("req_ready", {31'd0, v.c ? req1_ready : req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_alu_control", {28'd0, alu_control}, v.e ? 32'd0 : {28'd0, v.op});
    chk("exec_alu_a", alu_a, v.e ? 32'd0 : v.a);
    chk("exec_resp_valid", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    @(negedge clk);
    chk("resp_valid", {31'd0, v.c ? resp1_valid : resp0_valid}, 32'd1);
    chk("resp_other_valid", {31'd0, v.c ? resp0_valid : resp1_valid}, 32'd0);
    chk("resp_result", v.c ? resp1_result : resp0_result, v.res);
    chk("resp_zero", {31'd0, v.c ? resp1_zero : resp0_zero}, {31'd0, v.z});
    chk("resp_err", {31'd0, v.c ? resp1_err : resp0_err}, {31'd0, v.e});
    chk("resp_alu_idle", {28'd0, alu_control}, 32'd0);
    if (v.c) resp1_ready = 1; else resp0_ready = 1;
    @(negedge clk);
    resp0_ready = 0; resp1_ready = 0;
    chk("after_resp_valid", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    chk("after_resp_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    //            c   op       a             b             result        z  e
    vecs[0]  = '{1'b0, 4'b0000, 32'd5,        32'd7,        32'd12,       0, 0};
    vecs[1]  = '{1'b1, 4'b0001, 32'd9,        32'd9,        32'd0,        1, 0};
    vecs[2]  = '{1'b0, 4'b0010, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 0, 0};
    vecs[3]  = '{1'b1, 4'b0011, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 0};
    vecs[4]  = '{1'b0, 4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0, 0};
    vecs[5]  = '{1'b1, 4'b0101, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 0};
    vecs[6]  = '{1'b0, 4'b0101, 32'd5,        32'd3,        32'd0,        1, 0};
    vecs[7]  = '{1'b1, 4'b0110, 32'h80000000, 32'd4,        32'h08000000, 0, 0};
    vecs[8]  = '{1'b0, 4'b0111, 32'h80000000, 32'd4,        32'hF8000000, 0, 0};
    vecs[9]  = '{1'b1, 4'b1000, 32'd1,        32'd4,        32'd16,       0, 0};
    vecs[10] = '{1'b1, 4'b1111, 32'd3,        32'd3,        32'd0,        0, 1};
    vecs[11] = '{1'b0, 4'b1001, 32'd1,        32'd2,        32'd0,        0, 1};

    // Reset: held low from time 0, released mid-cycle.
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    chk("rst_alu", {alu_control, alu_a[27:0] | alu_b[27:0]}, 32'd0);
    #2 rst_n = 1;
    @(negedge clk);

    // Contention after reset: req0 (sub 9-9) wins, req1 (or) waits.
    req0_valid = 1; req0_op = 4'b0001; req0_a = 9;    req0_b = 9;
    req1_valid = 1; req1_op = 4'b0011; req1_a = 'hF0; req1_b = 'h0F;
    #1;
    chk("cont_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("cont_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 0;
    chk("cont_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    chk("cont_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    chk("cont_resp0_result", resp0_result, 32'd0);
    chk("cont_resp0_zero", {31'd0, resp0_zero}, 32'd1);
    chk("cont_resp_req1_ready", {31'd0, req1_ready}, 32'd0);
    resp0_ready = 1;
    #1;
    chk("cont_hs_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    resp0_ready = 0;
    chk("cont_req1_granted", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    chk("cont_resp1_valid", {31'd0, resp1_valid}, 32'd1);
    chk("cont_resp1_result", resp1_result, 32'h000000FF);
    resp1_ready = 1;
    @(negedge clk);
    resp1_ready = 0;

    // Table-driven single operations; the last one leaves rr pointing at 1.
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Simultaneous pair with rr = 1: req1 (sll 1,4) first, under backpressure.
    req0_valid = 1; req0_op = 4'b0000; req0_a = 2; req0_b = 3;
    req1_valid = 1; req1_op = 4'b1000; req1_a = 1; req1_b = 4;
    #1;
    chk("pair_req1_ready", {31'd0, req1_ready}, 32'd1);
    chk("pair_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
      chk("bp_resp1_result", resp1_result, 32'd16);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
    end
    resp1_ready = 1;
    #1;
    chk("bp_hs_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    resp1_ready = 0;
    chk("bp_req0_granted", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    chk("bp_resp0_result", resp0_result, 32'd5);
    chk("bp_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    resp0_ready = 1;
    @(negedge clk);
    resp0_ready = 0;

    // Reset pulsed during EXEC discards the in-flight xor.
    req0_valid = 1; req0_op = 4'b0100; req0_a = 32'h0F; req0_b = 32'hF0;
    @(negedge clk);
    req0_valid = 0;
    chk("rexec_busy_before", {31'd0, busy}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rexec_busy", {31'd0, busy}, 32'd0);
    chk("rexec_alu_control", {28'd0, alu_control}, 32'd0);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rexec_no_resp", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    end
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
